// File: rtl/mux_tree_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe_if
// Description : Handshake/data bundle for mux_tree_pipe.
//               master = upstream source plus downstream sink (the bench or
//               the surrounding datapath); slave = the mux tree itself.
//               Signals:
//                 in_data   N_IN*WIDTH  channel k at [k*WIDTH +: WIDTH]
//                 in_sel    SEL_W       channel index, sampled with in_valid
//                 in_valid  1           input beat present
//                 in_ready  1           block accepts a beat this cycle
//                 out_data  WIDTH       selected channel data
//                 out_sel   SEL_W       channel index that produced out_data
//                 out_valid 1           output beat present
//                 out_ready 1           downstream accepts a beat
//                 scan_mode 1           only when MUX_SCAN_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_tree_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 16
);
    localparam int SEL_W = $clog2(N_IN);

    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;
`ifdef MUX_SCAN_EN
    logic                  scan_mode;
`endif

    modport master (
`ifdef MUX_SCAN_EN
        output scan_mode,
`endif
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
`ifdef MUX_SCAN_EN
        input  scan_mode,
`endif
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe
// Description : N_IN:1 multiplexer of WIDTH-bit channels built as a radix-2
//               tree of LEVELS = $clog2(N_IN) levels. With PIPE=1 every level
//               is registered (latency LEVELS); with PIPE=0 only the final
//               level is registered (latency 1). valid/ready handshake with a
//               single global stall; the select index rides along as a tag.
//               Optional feature macro: MUX_SCAN_EN adds scan_mode and an
//               internal auto-incrementing channel pointer.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    mux_tree_pipe_if.slave (data, sel, handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 16,
    parameter int PIPE  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_tree_pipe_if.slave  bus
);
    localparam int LEVELS = $clog2(N_IN);
    localparam int SEL_W  = LEVELS;

    logic             w_adv;
    logic [SEL_W-1:0] w_sel;

    // Heap-indexed tree: node 1 is the root, leaves are N_IN..2*N_IN-1.
    // Children of node n are 2n and 2n+1, so the leaf pair feeding a level-0
    // node differs only in sel bit 0.
    logic [WIDTH-1:0] w_node    [1:2*N_IN-1];
    logic [SEL_W-1:0] w_lvl_sel [0:LEVELS];
    logic             w_lvl_vld [0:LEVELS];

    // Stall only when the output holds an unaccepted beat; everything advances together.
    assign w_adv        = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = w_adv;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] r_scan_ptr;

    // N_IN is a power of two, so natural SEL_W-bit overflow gives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_ptr <= '0;
        end else if (bus.scan_mode && bus.in_valid && w_adv) begin
            r_scan_ptr <= r_scan_ptr + 1'b1;
        end
    end

    assign w_sel = bus.scan_mode ? r_scan_ptr : bus.in_sel;
`else
    assign w_sel = bus.in_sel;
`endif

    assign w_lvl_sel[0] = w_sel;
    assign w_lvl_vld[0] = bus.in_valid;

    genvar gk, gj, gi;

    for (gk = 0; gk < N_IN; gk++) begin : g_leaf
        assign w_node[N_IN+gk] = bus.in_data[gk*WIDTH +: WIDTH];
    end

    for (gj = 0; gj < LEVELS; gj++) begin : g_lvl
        localparam int c_nodes = N_IN >> (gj + 1);

        if (PIPE == 1 || gj == LEVELS - 1) begin : g_tag_reg
            logic             r_vld;
            logic [SEL_W-1:0] r_sel;

            // Tag loads only with a real beat so it keeps the last value
            // across bubbles, matching the data registers below.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_sel <= '0;
                end else if (w_adv) begin
                    r_vld <= w_lvl_vld[gj];
                    if (w_lvl_vld[gj]) begin
                        r_sel <= w_lvl_sel[gj];
                    end
                end
            end

            assign w_lvl_vld[gj+1] = r_vld;
            assign w_lvl_sel[gj+1] = r_sel;
        end else begin : g_tag_comb
            assign w_lvl_vld[gj+1] = w_lvl_vld[gj];
            assign w_lvl_sel[gj+1] = w_lvl_sel[gj];
        end

        for (gi = 0; gi < c_nodes; gi++) begin : g_node
            localparam int c_idx = c_nodes + gi;
            logic [WIDTH-1:0] w_mux;

            // Level gj resolves sel bit gj of the tag that arrived with this beat.
            assign w_mux = w_lvl_sel[gj][gj] ? w_node[2*c_idx+1] : w_node[2*c_idx];

            if (PIPE == 1 || gj == LEVELS - 1) begin : g_data_reg
                logic [WIDTH-1:0] r_data;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_data <= '0;
                    end else if (w_adv && w_lvl_vld[gj]) begin
                        r_data <= w_mux;
                    end
                end

                assign w_node[c_idx] = r_data;
            end else begin : g_data_comb
                assign w_node[c_idx] = w_mux;
            end
        end
    end

    assign bus.out_data  = w_node[1];
    assign bus.out_sel   = w_lvl_sel[LEVELS];
    assign bus.out_valid = w_lvl_vld[LEVELS];

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_tree_pipe
// Description : Scoreboard bench for mux_tree_pipe. Three instances:
//               A defaults (WIDTH 8, N_IN 16, PIPE 1), B (WIDTH 16, N_IN 4,
//               PIPE 0), C (WIDTH 1, N_IN 2, PIPE 1). Accepted beats push an
//               expected entry; output monitors pop and compare on transfer.
//               Scan-pointer sequence is exercised when MUX_SCAN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_tree_pipe;
    localparam int LAT_A = 4;
    localparam int LAT_B = 1;
    localparam int LAT_C = 1;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  sel;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   lat_a, lat_b, lat_c;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t c_q[$];

    logic [7:0]  a_chan [16];
    logic [15:0] b_chan [4];
    logic        c_chan [2];
`ifdef MUX_SCAN_EN
    logic [3:0]  a_scan;
`endif

    mux_tree_pipe_if #(.WIDTH(8),  .N_IN(16)) a_if ();
    mux_tree_pipe_if #(.WIDTH(16), .N_IN(4))  b_if ();
    mux_tree_pipe_if #(.WIDTH(1),  .N_IN(2))  c_if ();

    mux_tree_pipe #(.WIDTH(8),  .N_IN(16), .PIPE(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    mux_tree_pipe #(.WIDTH(16), .N_IN(4),  .PIPE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    mux_tree_pipe #(.WIDTH(1),  .N_IN(2),  .PIPE(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endfunction

    // ---------------- monitors (sample on the falling edge) ----------------
    always @(negedge clk) begin : mon_a
        exp_t e;
        logic [3:0] s;
        if (rst_n) begin
            if (a_if.in_valid && a_if.in_ready) begin
                s = a_if.in_sel;
`ifdef MUX_SCAN_EN
                if (a_if.scan_mode) begin
                    s = a_scan;
                    a_scan = a_scan + 4'd1;
                end
`endif
                e.data = 16'(a_chan[s]);
                e.sel  = s;
                e.acc  = cyc;
                e.lat  = lat_a;
                a_q.push_back(e);
            end
            if (a_if.out_valid && a_if.out_ready) begin
                if (a_q.size() == 0) begin
                    fail_now("a_unexpected_beat");
                end else begin
                    e = a_q.pop_front();
                    chk("a_data", 32'(a_if.out_data), 32'(e.data));
                    chk("a_sel",  32'(a_if.out_sel),  32'(e.sel));
                    if (e.lat) chk("a_latency", 32'(cyc - e.acc), LAT_A);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n) begin
            if (b_if.in_valid && b_if.in_ready) begin
                e.data = b_chan[b_if.in_sel];
                e.sel  = 4'(b_if.in_sel);
                e.acc  = cyc;
                e.lat  = lat_b;
                b_q.push_back(e);
            end
            if (b_if.out_valid && b_if.out_ready) begin
                if (b_q.size() == 0) begin
                    fail_now("b_unexpected_beat");
                end else begin
                    e = b_q.pop_front();
                    chk("b_data", 32'(b_if.out_data), 32'(e.data));
                    chk("b_sel",  32'(b_if.out_sel),  32'(e.sel));
                    if (e.lat) chk("b_latency", 32'(cyc - e.acc), LAT_B);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rst_n) begin
            if (c_if.in_valid && c_if.in_ready) begin
                e.data = 16'(c_chan[c_if.in_sel]);
                e.sel  = 4'(c_if.in_sel);
                e.acc  = cyc;
                e.lat  = lat_c;
                c_q.push_back(e);
            end
            if (c_if.out_valid && c_if.out_ready) begin
                if (c_q.size() == 0) begin
                    fail_now("c_unexpected_beat");
                end else begin
                    e = c_q.pop_front();
                    chk("c_data", 32'(c_if.out_data), 32'(e.data));
                    chk("c_sel",  32'(c_if.out_sel),  32'(e.sel));
                    if (e.lat) chk("c_latency", 32'(cyc - e.acc), LAT_C);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic a_send(input logic [3:0] sel);
        int n;
        @(posedge clk); #1;
        a_if.in_valid = 1'b1;
        a_if.in_sel   = sel;
        n = 0;
        @(negedge clk);
        while (!a_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_if.in_ready) fail_now("a_in_ready_timeout");
    endtask

    task automatic b_send(input logic [1:0] sel);
        @(posedge clk); #1;
        b_if.in_valid = 1'b1;
        b_if.in_sel   = sel;
        @(negedge clk);
        if (!b_if.in_ready) fail_now("b_in_ready_low");
    endtask

    task automatic c_send(input logic sel);
        @(posedge clk); #1;
        c_if.in_valid = 1'b1;
        c_if.in_sel   = sel;
        @(negedge clk);
        if (!c_if.in_ready) fail_now("c_in_ready_low");
    endtask

    task automatic idle_all();
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        c_if.in_valid = 1'b0;
    endtask

    task automatic drain(input int which);
        int n;
        int sz;
        n = 0;
        sz = (which == 0) ? a_q.size() : (which == 1) ? b_q.size() : c_q.size();
        while (sz != 0 && n < 100) begin
            @(negedge clk);
            n++;
            sz = (which == 0) ? a_q.size() : (which == 1) ? b_q.size() : c_q.size();
        end
        if (sz != 0) fail_now("drain_timeout");
        repeat (6) @(negedge clk);   // leaves room for any extra beat to be caught
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        n_checks = 0;
        n_errors = 0;
        lat_a = 0; lat_b = 0; lat_c = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 16; k++) a_chan[k] = 8'hA0 + 8'(k);
        b_chan[0] = 16'h0123; b_chan[1] = 16'h4567; b_chan[2] = 16'hBEEF; b_chan[3] = 16'hCAFE;
        c_chan[0] = 1'b0;     c_chan[1] = 1'b1;
        for (int k = 0; k < 16; k++) a_if.in_data[k*8 +: 8] = a_chan[k];
        for (int k = 0; k < 4; k++)  b_if.in_data[k*16 +: 16] = b_chan[k];
        c_if.in_data = 2'b10;
        a_if.in_valid = 0; a_if.in_sel = '0; a_if.out_ready = 1;
        b_if.in_valid = 0; b_if.in_sel = '0; b_if.out_ready = 1;
        c_if.in_valid = 0; c_if.in_sel = '0; c_if.out_ready = 1;
`ifdef MUX_SCAN_EN
        a_if.scan_mode = 1'b0;
        a_scan = 4'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_if.out_valid), 0);
        chk("rst_a_data",  32'(a_if.out_data),  0);
        chk("rst_a_sel",   32'(a_if.out_sel),   0);
        chk("rst_a_ready", 32'(a_if.in_ready),  1);
        chk("rst_b_valid", 32'(b_if.out_valid), 0);
        chk("rst_c_valid", 32'(c_if.out_valid), 0);
        rst_n = 1'b1;

        // Sweep all channels back to back: A0..AF, 4-cycle latency, 1 beat/cycle.
        lat_a = 1;
        for (int s = 0; s < 16; s++) a_send(4'(s));
        idle_all();
        drain(0);
        lat_a = 0;

        // Stall: three beats in with the sink blocked.
        @(posedge clk); #1;
        a_if.out_ready = 1'b0;
        a_send(4'd3);
        a_send(4'd9);
        a_send(4'd12);
        idle_all();
        n = 0;
        while (!a_if.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_if.out_valid) fail_now("a_stall_wait_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  32'(a_if.in_ready),  0);
            chk("stall_out_valid", 32'(a_if.out_valid), 1);
            chk("stall_out_data",  32'(a_if.out_data),  32'h0000_00A3);
            chk("stall_out_sel",   32'(a_if.out_sel),   3);
        end
        @(posedge clk); #1;
        a_if.out_ready = 1'b1;
        drain(0);

        // Asynchronous reset with four beats in flight (beat 1 already at the output).
        a_send(4'd1);
        a_send(4'd2);
        a_send(4'd3);
        a_send(4'd4);
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        #2;
        chk("pre_rst_out_valid", 32'(a_if.out_valid), 1);
        rst_n = 1'b0;
        a_q.delete();
`ifdef MUX_SCAN_EN
        a_scan = 4'd0;
`endif
        #1;
        chk("async_rst_valid", 32'(a_if.out_valid), 0);
        chk("async_rst_data",  32'(a_if.out_data),  0);
        chk("async_rst_sel",   32'(a_if.out_sel),   0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_send(4'd10);
        a_send(4'd11);
        idle_all();
        drain(0);

`ifdef MUX_SCAN_EN
        // Scan pointer: 18 beats with a bubble after beat 5, in_sel held at 7.
        @(posedge clk); #1;
        a_if.scan_mode = 1'b1;
        for (int i = 0; i < 18; i++) begin
            a_send(4'd7);
            if (i == 4) idle_all();
        end
        idle_all();
        drain(0);
        chk("scan_ptr_model_end", 32'(a_scan), 2);
        @(posedge clk); #1;
        a_if.scan_mode = 1'b0;
`endif

        // PIPE=0, 4 channels of 16 bits: single-cycle latency, ch2 = BEEF.
        lat_b = 1;
        b_send(2'd2);
        b_send(2'd0);
        b_send(2'd3);
        b_send(2'd1);
        idle_all();
        drain(1);

        // Two 1-bit channels, in_data = 2'b10: alternate sel gives 0,1,0,1.
        lat_c = 1;
        c_send(1'b0);
        c_send(1'b1);
        c_send(1'b0);
        c_send(1'b1);
        idle_all();
        drain(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
